multi_timer: RTL and testbench

- Parametrised successor to the single-channel peripheral timer: N_CH independent up-counting channels.
- Each channel has its own prescaler, compare/period register, periodic or one-shot mode, and an interrupt enable.
- Sits on the same simple memory-mapped peripheral bus (address, wr_en/rd_en, wr_data/rd_data).
- Raises one combined level interrupt to the SoC interrupt controller; per-channel status is write-1-to-clear.

---
 rtl/multi_timer.sv | 178 +++++++++++++++++
 tb/tb_multi_timer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// multi_timer: N_CH independent prescaled up-counters behind a simple peripheral bus.
// Define MULTI_TIMER_PWM_EN to add per-channel DUTY registers and the pwm_out port.

module multi_timer_ch #(
    parameter int CNT_WIDTH = 32,
    parameter int PSC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_we,
    input  logic                 cnt_we,
    input  logic                 cmp_we,
    input  logic                 psc_we,
`ifdef MULTI_TIMER_PWM_EN
    input  logic                 duty_we,
    output logic [CNT_WIDTH-1:0] duty,
    output logic                 pwm,
`endif
    input  logic [31:0]          wdata,
    output logic                 en,
    output logic                 ie,
    output logic                 oneshot,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic [CNT_WIDTH-1:0] cmp,
    output logic [PSC_WIDTH-1:0] psc,
    output logic                 wrap
);
    logic [PSC_WIDTH-1:0] pcnt, pcnt_n;
    logic [CNT_WIDTH-1:0] cnt_n;
    logic                 en_n, clr, tick, hit;

    assign clr  = ctrl_we && wdata[3];
    assign tick = en && (pcnt == psc);
    assign hit  = tick && (cnt == cmp);
    // A software CNT write or CLR on the same edge overrides the hardware wrap.
    assign wrap = hit && !cnt_we && !clr;

    always_comb begin
        en_n   = en;
        cnt_n  = cnt;
        pcnt_n = pcnt;
        if (ctrl_we)
            en_n = wdata[0];
        else if (hit && oneshot)
            en_n = 1'b0;
        if (cnt_we)
            cnt_n = wdata[CNT_WIDTH-1:0];
        else if (clr)
            cnt_n = '0;
        else if (tick)
            cnt_n = hit ? '0 : cnt + CNT_WIDTH'(1);
        if (cnt_we || clr)
            pcnt_n = '0;
        else if (en)
            pcnt_n = tick ? '0 : pcnt + PSC_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            oneshot <= 1'b0;
            cnt     <= '0;
            cmp     <= '0;
            psc     <= '0;
            pcnt    <= '0;
        end else begin
            en   <= en_n;
            cnt  <= cnt_n;
            pcnt <= pcnt_n;
            if (ctrl_we) begin
                ie      <= wdata[1];
                oneshot <= wdata[2];
            end
            if (cmp_we) cmp <= wdata[CNT_WIDTH-1:0];
            if (psc_we) psc <= wdata[PSC_WIDTH-1:0];
        end
    end

`ifdef MULTI_TIMER_PWM_EN
    logic [CNT_WIDTH-1:0] duty_n;
    assign duty_n = duty_we ? wdata[CNT_WIDTH-1:0] : duty;

    // Built from post-edge state so pwm matches the EN/CNT visible in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= '0;
            pwm  <= 1'b0;
        end else begin
            duty <= duty_n;
            pwm  <= en_n && (cnt_n < duty_n);
        end
    end
`endif
endmodule

module multi_timer #(
    parameter int N_CH      = 4,
    parameter int CNT_WIDTH = 32,
    parameter int PSC_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     address,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    output logic            interrupt
`ifdef MULTI_TIMER_PWM_EN
    ,
    output logic [N_CH-1:0] pwm_out
`endif
);
    localparam logic [31:0] STATUS_ADDR = 32'(N_CH * 16);

    logic [N_CH-1:0]                en, ie, oneshot, wrap, status;
    logic [N_CH-1:0][CNT_WIDTH-1:0] cnt, cmp;
    logic [N_CH-1:0][PSC_WIDTH-1:0] psc;
`ifdef MULTI_TIMER_PWM_EN
    logic [N_CH-1:0][CNT_WIDTH-1:0] duty;
`endif
    logic [31:0]                    rd_mux;
    logic                           status_we;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        localparam logic [31:0] BASE = 32'(g * 16);
        multi_timer_ch #(.CNT_WIDTH(CNT_WIDTH), .PSC_WIDTH(PSC_WIDTH)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ctrl_we (wr_en && (address == BASE)),
            .cnt_we  (wr_en && (address == BASE + 32'd4)),
            .cmp_we  (wr_en && (address == BASE + 32'd8)),
            .psc_we  (wr_en && (address == BASE + 32'd12)),
`ifdef MULTI_TIMER_PWM_EN
            .duty_we (wr_en && (address == STATUS_ADDR + 32'(16 + g * 4))),
            .duty    (duty[g]),
            .pwm     (pwm_out[g]),
`endif
            .wdata   (wr_data),
            .en      (en[g]),
            .ie      (ie[g]),
            .oneshot (oneshot[g]),
            .cnt     (cnt[g]),
            .cmp     (cmp[g]),
            .psc     (psc[g]),
            .wrap    (wrap[g])
        );
    end

    // Hardware set takes priority over a same-cycle write-1-to-clear.
    assign status_we = wr_en && (address == STATUS_ADDR);
    always_ff @(posedge clk) begin
        if (rst) status <= '0;
        else     status <= wrap | (status & ~({N_CH{status_we}} & wr_data[N_CH-1:0]));
    end

    assign interrupt = |(status & ie);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (address == 32'(i * 16))      rd_mux = {29'd0, oneshot[i], ie[i], en[i]};
            if (address == 32'(i * 16 + 4))  rd_mux = 32'(cnt[i]);
            if (address == 32'(i * 16 + 8))  rd_mux = 32'(cmp[i]);
            if (address == 32'(i * 16 + 12)) rd_mux = 32'(psc[i]);
`ifdef MULTI_TIMER_PWM_EN
            if (address == STATUS_ADDR + 32'(16 + i * 4)) rd_mux = 32'(duty[i]);
`endif
        end
        if (address == STATUS_ADDR) rd_mux = 32'(status);
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else     rd_data <= rd_en ? rd_mux : '0;
    end
endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (N_CH=4, CNT_WIDTH=8, PSC_WIDTH=32).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.

module tb_multi_timer;
    logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, wr_data = '0;
    logic [31:0] rd_data;
    logic        interrupt;
`ifdef MULTI_TIMER_PWM_EN
    logic [3:0]  pwm_out;
`endif
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    multi_timer #(.N_CH(4), .CNT_WIDTH(8), .PSC_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
`ifdef MULTI_TIMER_PWM_EN
        .pwm_out   (pwm_out),
`endif
        .interrupt (interrupt)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        address = a; wr_data = v; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        address = a; rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        v = rd_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        vectors++;
        if (interrupt !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", interrupt); end
        vectors++;
        if (rd_data !== 32'd0) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
`ifdef MULTI_TIMER_PWM_EN
        vectors++;
        if (pwm_out !== 4'd0) begin miscompares++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
`endif
        for (int a = 0; a < 'h60; a += 4) begin
            rd(32'(a), v);
            vectors++;
            if (v !== 32'd0) begin miscompares++; $display("FAIL reset_read @%0h: got %h expected 0", a, v); end
        end
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        wr(32'h0C, 0); wr(32'h08, 4); wr(32'h00, 3);   // enable edge E0
        step(4);
        vectors++;
        if (interrupt !== 1'b0) begin miscompares++; $display("FAIL periodic_early: got %b expected 0", interrupt); end
        step(1);                                        // wrap on E5
        vectors++;
        if (interrupt !== 1'b1) begin miscompares++; $display("FAIL periodic_first: got %b expected 1", interrupt); end
        rd(32'h40, v);
        vectors++;
        if (v !== 32'h1) begin miscompares++; $display("FAIL periodic_status: got %h expected 1", v); end
        rd(32'h04, v);
        vectors++;
        if (v !== 32'h1) begin miscompares++; $display("FAIL periodic_cnt: got %h expected 1", v); end
        wr(32'h40, 1);                                  // W1C on E8
        vectors++;
        if (interrupt !== 1'b0) begin miscompares++; $display("FAIL w1c_drop: got %b expected 0", interrupt); end
        step(2);                                        // next wrap on E10
        vectors++;
        if (interrupt !== 1'b1) begin miscompares++; $display("FAIL periodic_repeat: got %b expected 1", interrupt); end
        wr(32'h00, 0);                                  // EN=0, IE=0 on E11
        vectors++;
        if (interrupt !== 1'b0) begin miscompares++; $display("FAIL ie_mask: got %b expected 0", interrupt); end
        rd(32'h40, v);
        vectors++;
        if (v !== 32'h1) begin miscompares++; $display("FAIL status_kept: got %h expected 1", v); end
        wr(32'h40, 1);
        rd(32'h40, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL status_w1c: got %h expected 0", v); end
        rd(32'h04, v);
        vectors++;
        if (v !== 32'h1) begin miscompares++; $display("FAIL cnt_hold: got %h expected 1", v); end
        wr(32'h00, 8);
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        wr(32'h1C, 3); wr(32'h18, 2); wr(32'h10, 7);   // enable edge E0
        step(11);
        vectors++;
        if (interrupt !== 1'b0) begin miscompares++; $display("FAIL oneshot_early: got %b expected 0", interrupt); end
        step(1);                                        // wrap on E12
        vectors++;
        if (interrupt !== 1'b1) begin miscompares++; $display("FAIL oneshot_fire: got %b expected 1", interrupt); end
        rd(32'h10, v);
        vectors++;
        if (v !== 32'h6) begin miscompares++; $display("FAIL oneshot_ctrl: got %h expected 6", v); end
        step(8);
        rd(32'h14, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL oneshot_cnt: got %h expected 0", v); end
        rd(32'h40, v);
        vectors++;
        if (v !== 32'h2) begin miscompares++; $display("FAIL oneshot_status: got %h expected 2", v); end
        wr(32'h40, 2);
        vectors++;
        if (interrupt !== 1'b0) begin miscompares++; $display("FAIL oneshot_clear: got %b expected 0", interrupt); end
        wr(32'h10, 0);
    endtask

    task automatic test_set_wins();
        logic [31:0] v;
        wr(32'h2C, 0); wr(32'h28, 3); wr(32'h20, 1);   // wraps on E4, E8, ...
        step(7);
        wr(32'h40, 4);                                  // W1C lands on E8
        rd(32'h40, v);
        vectors++;
        if (v !== 32'h4) begin miscompares++; $display("FAIL set_wins: got %h expected 4", v); end
        wr(32'h40, 4);                                  // E10, no wrap
        rd(32'h40, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL plain_w1c: got %h expected 0", v); end
        wr(32'h20, 8);
        wr(32'h40, 4);
    endtask

    task automatic test_cnt_write();
        logic [31:0] v;
        wr(32'h3C, 2); wr(32'h38, 100); wr(32'h30, 1); // ticks on E3, E6, ...
        step(5);
        wr(32'h34, 50);                                 // lands on tick edge E6
        rd(32'h34, v);
        vectors++;
        if (v !== 32'd50) begin miscompares++; $display("FAIL cnt_write_tick: got %0d expected 50", v); end
        wr(32'h34, 80);                                 // mid-prescale on E8
        step(2);
        rd(32'h34, v);
        vectors++;
        if (v !== 32'd80) begin miscompares++; $display("FAIL psc_restart: got %0d expected 80", v); end
        rd(32'h34, v);
        vectors++;
        if (v !== 32'd81) begin miscompares++; $display("FAIL psc_restart_tick: got %0d expected 81", v); end
        wr(32'h30, 8);
    endtask

    task automatic test_rollover();
        logic [31:0] v;
        wr(32'h08, 200); wr(32'h04, 10); wr(32'h00, 3); // E0: CNT 10 running
        wr(32'h08, 5);                                  // E1: CMP below CNT
        step(244);
        vectors++;
        if (interrupt !== 1'b0) begin miscompares++; $display("FAIL rollover_early: got %b expected 0", interrupt); end
        rd(32'h04, v);
        vectors++;
        if (v !== 32'hFF) begin miscompares++; $display("FAIL rollover_max: got %h expected ff", v); end
        step(5);
        vectors++;
        if (interrupt !== 1'b0) begin miscompares++; $display("FAIL rollover_silent: got %b expected 0", interrupt); end
        step(1);
        vectors++;
        if (interrupt !== 1'b1) begin miscompares++; $display("FAIL rollover_hit: got %b expected 1", interrupt); end
        rd(32'h40, v);
        vectors++;
        if (v !== 32'h1) begin miscompares++; $display("FAIL rollover_status: got %h expected 1", v); end
        wr(32'h00, 8);
        wr(32'h40, 32'hF);
    endtask

    task automatic test_bus();
        logic [31:0] v;
        address = 32'h18; wr_data = 7; wr_en = 1'b1; rd_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        vectors++;
        if (rd_data !== 32'h2) begin miscompares++; $display("FAIL rw_same: got %h expected 2", rd_data); end
        rd(32'h18, v);
        vectors++;
        if (v !== 32'h7) begin miscompares++; $display("FAIL rw_new: got %h expected 7", v); end
        step(1);
        vectors++;
        if (rd_data !== 32'h0) begin miscompares++; $display("FAIL rd_idle: got %h expected 0", rd_data); end
        wr(32'h18, 32'h12345);
        rd(32'h18, v);
        vectors++;
        if (v !== 32'h45) begin miscompares++; $display("FAIL cmp_trunc: got %h expected 45", v); end
        wr(32'h10, 32'hE);
        rd(32'h10, v);
        vectors++;
        if (v !== 32'h6) begin miscompares++; $display("FAIL clr_reads0: got %h expected 6", v); end
        wr(32'h10, 0);
        wr(32'h80, 32'hFFFF);
        rd(32'h80, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL unmapped: got %h expected 0", v); end
        wr(32'h44, 32'hFFFF);
        rd(32'h44, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL reserved: got %h expected 0", v); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] v;
        wr(32'h08, 2); wr(32'h00, 3);                   // would wrap on E3
        step(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (interrupt !== 1'b0) begin miscompares++; $display("FAIL rst_irq: got %b expected 0", interrupt); end
        rd(32'h00, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL rst_ctrl: got %h expected 0", v); end
        rd(32'h08, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL rst_cmp: got %h expected 0", v); end
        rd(32'h40, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL rst_status: got %h expected 0", v); end
    endtask

`ifdef MULTI_TIMER_PWM_EN
    task automatic test_pwm();
        logic [31:0] v;
        wr(32'h08, 9); wr(32'h50, 3);
        rd(32'h50, v);
        vectors++;
        if (v !== 32'h3) begin miscompares++; $display("FAIL duty_read: got %h expected 3", v); end
        wr(32'h00, 1);
        for (int k = 0; k < 20; k++) begin
            vectors++;
            if (pwm_out[0] !== ((k % 10) < 3)) begin
                miscompares++;
                $display("FAIL pwm_cycle %0d: got %b expected %b", k, pwm_out[0], (k % 10) < 3);
            end
            step(1);
        end
        wr(32'h00, 0);
        vectors++;
        if (pwm_out[0] !== 1'b0) begin miscompares++; $display("FAIL pwm_disable: got %b expected 0", pwm_out[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_set_wins();
        test_cnt_write();
        test_rollover();
        test_bus();
        test_reset_midcount();
`ifdef MULTI_TIMER_PWM_EN
        test_pwm();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
